// File: rtl/sy_mem_arb.sv
// Purpose: shares one memory port between instruction fetch (IF) and the load/store unit (LSU).
// Latency: a request accepted in cycle N is presented on mem_req_* in cycle N+1; responses route with zero latency.
// Backpressure: a loaded request is held until mem_req_ready_i; no requester is ready while OSTD requests are in flight.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   if_req_*              IF read requests (valid/addr/ready)
//   lsu_req_*             LSU requests (valid/addr/we/wdata/be/ready)
//   mem_req_*             registered request stage towards memory (valid/ready handshake)
//   mem_rsp_*             in-order memory responses, one per request
//   if_rsp_valid_o,
//   lsu_rsp_valid_o,
//   rsp_rdata_o           response routed back to its originator
//   ostd_cnt_o            number of accepted requests still waiting for a response
//   err_o                 sticky: a response arrived with nothing outstanding
//
// Build option: define SY_MEM_ARB_LSU_PRIO_EN to give the LSU fixed priority over IF;
// by default the two requesters are served round-robin on a tie.

// Grant-ID FIFO: records who issued each outstanding request, in order.
// Latency: head reflects a push on the following cycle.
// Backpressure: push when full and pop when empty are ignored; the caller bounds pushes.
module sy_mem_arb_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [W-1:0]               push_dat_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_dat_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty_o    = (cnt_q == '0);
    assign push_ok    = push_i & (cnt_q < CW'(DEPTH));
    assign pop_ok     = pop_i & ~empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign cnt_o      = cnt_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end
endmodule

module sy_mem_arb #(
    parameter int AWTH = 64,
    parameter int DWTH = 64,
    parameter int OSTD = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    if_req_valid_i,
    input  logic [AWTH-1:0]         if_req_addr_i,
    output logic                    if_req_ready_o,
    input  logic                    lsu_req_valid_i,
    input  logic [AWTH-1:0]         lsu_req_addr_i,
    input  logic                    lsu_req_we_i,
    input  logic [DWTH-1:0]         lsu_req_wdata_i,
    input  logic [DWTH/8-1:0]       lsu_req_be_i,
    output logic                    lsu_req_ready_o,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic [AWTH-1:0]         mem_req_addr_o,
    output logic                    mem_req_we_o,
    output logic [DWTH-1:0]         mem_req_wdata_o,
    output logic [DWTH/8-1:0]       mem_req_be_o,
    input  logic                    mem_rsp_valid_i,
    input  logic [DWTH-1:0]         mem_rsp_rdata_i,
    output logic                    if_rsp_valid_o,
    output logic                    lsu_rsp_valid_o,
    output logic [DWTH-1:0]         rsp_rdata_o,
    output logic [$clog2(OSTD):0]   ostd_cnt_o,
    output logic                    err_o
);
    localparam int CW = $clog2(OSTD) + 1;
    localparam int BW = DWTH / 8;

    logic            vld_q, vld_d;
    logic [AWTH-1:0] addr_q, addr_d;
    logic            we_q, we_d;
    logic [DWTH-1:0] wdata_q, wdata_d;
    logic [BW-1:0]   be_q, be_d;
    logic            last_lsu_q, last_lsu_d;   // 0: IF granted last, 1: LSU granted last
    logic            err_q, err_d;

    logic            stage_free;
    logic            issue;
    logic            grant_lsu;
    logic            grant_if;
    logic            accept;
    logic            gid_head;
    logic            gid_empty;
    logic            rsp_pop;
    logic [CW-1:0]   ostd_cnt;

    // The stage may reload when empty or when memory takes its content this cycle.
    // The in-flight limit uses the registered count, so a same-cycle response does not help.
    assign stage_free = ~vld_q | mem_req_ready_i;
    assign issue      = ~rst_i & stage_free & (ostd_cnt < CW'(OSTD));

`ifdef SY_MEM_ARB_LSU_PRIO_EN
    assign grant_lsu = lsu_req_valid_i;
`else
    // On a tie the requester not granted last wins.
    assign grant_lsu = lsu_req_valid_i & (~if_req_valid_i | ~last_lsu_q);
`endif
    assign grant_if  = if_req_valid_i & ~grant_lsu;

    assign if_req_ready_o  = issue & grant_if;
    assign lsu_req_ready_o = issue & grant_lsu;
    assign accept          = if_req_ready_o | lsu_req_ready_o;

    always_comb begin
        vld_d      = vld_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        last_lsu_d = last_lsu_q;
        if (stage_free) begin
            vld_d = accept;
        end
        if (lsu_req_ready_o) begin
            addr_d     = lsu_req_addr_i;
            we_d       = lsu_req_we_i;
            wdata_d    = lsu_req_wdata_i;
            be_d       = lsu_req_be_i;
            last_lsu_d = 1'b1;
        end else if (if_req_ready_o) begin
            addr_d     = if_req_addr_i;
            we_d       = 1'b0;
            wdata_d    = '0;
            be_d       = '0;
            last_lsu_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q      <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            last_lsu_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            last_lsu_q <= last_lsu_d;
            err_q      <= err_d;
        end
    end

    sy_mem_arb_fifo #(
        .W     (1),
        .DEPTH (OSTD)
    ) u_gid_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (accept),
        .push_dat_i (lsu_req_ready_o),
        .pop_i      (mem_rsp_valid_i),
        .head_dat_o (gid_head),
        .empty_o    (gid_empty),
        .cnt_o      (ostd_cnt)
    );

    // A response with nothing outstanding is dropped and flagged until reset.
    assign rsp_pop = mem_rsp_valid_i & ~gid_empty;
    assign err_d   = err_q | (mem_rsp_valid_i & gid_empty);

    assign if_rsp_valid_o  = rsp_pop & ~gid_head;
    assign lsu_rsp_valid_o = rsp_pop & gid_head;
    assign rsp_rdata_o     = mem_rsp_rdata_i;

    assign mem_req_valid_o = vld_q;
    assign mem_req_addr_o  = addr_q;
    assign mem_req_we_o    = we_q;
    assign mem_req_wdata_o = wdata_q;
    assign mem_req_be_o    = be_q;
    assign ostd_cnt_o      = ostd_cnt;
    assign err_o           = err_q;
endmodule
